// File: rtl/addr_trace_feeder_if.sv
// Handshake bundle for addr_trace_feeder: trace-word load port and cache issue port.
// master = trace source / cache side, slave = the feeder.
interface addr_trace_feeder_if #(
  parameter int ADDR_W = 32
);
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic              load_ready;
  logic              addr_valid;
  logic [ADDR_W-1:0] address;
  logic              addr_ready;

  modport master (
    output load_valid, load_addr, addr_ready,
    input  load_ready, addr_valid, address
  );

  modport slave (
    input  load_valid, load_addr, addr_ready,
    output load_ready, addr_valid, address
  );
endinterface

// File: rtl/addr_trace_feeder.sv
// Buffers a trace of addresses in a FIFO and issues a requested number of them to a cache.
// Define ADDR_TRACE_FEEDER_STATS_EN to add stall_cnt (RUN cycles spent with the FIFO empty).
module addr_trace_feeder #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  addr_trace_feeder_if.slave   bus,
  input  logic                 start,
  input  logic [CNT_W-1:0]     trace_len,
  output logic [CNT_W-1:0]     count,
  output logic                 busy,
  output logic                 done
`ifdef ADDR_TRACE_FEEDER_STATS_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("addr_trace_feeder: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  count_inc;
  logic              start_acc;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  // Pointers carry one extra wrap bit so equal indices can be told apart as full or empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign bus.load_ready = !full;
  assign bus.addr_valid = (state == RUN) && !empty;
  assign bus.address    = mem[rd_ptr[PTR_W-1:0]];

  // A full FIFO refuses loads even when a pop happens on the same edge.
  assign push      = bus.load_valid && !full;
  assign pop       = bus.addr_valid && bus.addr_ready;
  assign start_acc = start && (state != RUN);
  assign count_inc = count + CNT_W'(1);

  // NOTE: storage is not reset; emptiness is tracked by the pointers alone, so stale
  // contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= bus.load_addr;
    end
  end

  // NOTE: every sequential block uses non-blocking assignments so all state
  // updates on an edge see the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      len   <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len   <= trace_len;
            count <= '0;
            if (trace_len == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (pop) begin
            count <= count_inc;
            if (count_inc == len) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADDR_TRACE_FEEDER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && empty && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_addr_trace_feeder.sv
// Directed self-checking bench for addr_trace_feeder; stall_cnt is exercised
// only when ADDR_TRACE_FEEDER_STATS_EN is defined.
module tb_addr_trace_feeder;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 20;

  logic             clock;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] trace_len;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
`ifdef ADDR_TRACE_FEEDER_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  addr_trace_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  addr_trace_feeder #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .start    (start),
    .trace_len(trace_len),
    .count    (count),
    .busy     (busy),
    .done     (done)
`ifdef ADDR_TRACE_FEEDER_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a);
    bus.load_valid = 1'b1;
    bus.load_addr  = a;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic start_run(input logic [CNT_W-1:0] n);
    start     = 1'b1;
    trace_len = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    trace_len      = '0;
    bus.load_valid = 1'b0;
    bus.load_addr  = '0;
    bus.addr_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_addr_valid", 64'(bus.addr_valid), 64'd0);
    check("rst_busy",       64'(busy),           64'd0);
    check("rst_done",       64'(done),           64'd0);
    check("rst_load_ready", 64'(bus.load_ready), 64'd1);
    check("rst_count",      64'(count),          64'd0);

    // Three words, issued back to back
    load_word(32'h10);
    load_word(32'h20);
    load_word(32'h30);
    check("idle_no_valid", 64'(bus.addr_valid), 64'd0);
    bus.addr_ready = 1'b1;
    start_run(CNT_W'(3));
    check("run_busy",   64'(busy),           64'd1);
    check("run_valid",  64'(bus.addr_valid), 64'd1);
    check("run_addr0",  64'(bus.address),    64'h10);
    check("run_count0", 64'(count),          64'd0);
    tick();
    check("run_addr1",  64'(bus.address),    64'h20);
    check("run_count1", 64'(count),          64'd1);
    tick();
    check("run_addr2",  64'(bus.address),    64'h30);
    check("run_count2", 64'(count),          64'd2);
    tick();
    check("run_count3", 64'(count),          64'd3);
    check("run_done",   64'(done),           64'd1);
    check("run_busy_0", 64'(busy),           64'd0);
    check("done_valid", 64'(bus.addr_valid), 64'd0);

    // Zero-length run with a word waiting: straight to DONE, nothing issued
    load_word(32'hAA);
    start_run('0);
    check("zl_done",  64'(done),           64'd1);
    check("zl_busy",  64'(busy),           64'd0);
    check("zl_count", 64'(count),          64'd0);
    check("zl_valid", 64'(bus.addr_valid), 64'd0);
    tick();
    check("zl_valid2", 64'(bus.addr_valid), 64'd0);

    // The waiting word survives DONE and is issued by the next run
    start_run(CNT_W'(1));
    check("persist_valid", 64'(bus.addr_valid), 64'd1);
    check("persist_addr",  64'(bus.address),    64'hAA);
    tick();
    check("persist_done",  64'(done),  64'd1);
    check("persist_count", 64'(count), 64'd1);

    // Fill to DEPTH with no issue, then try one more load
    bus.addr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      load_word(ADDR_W'(32'h100 + i));
      check($sformatf("fill_ready_%0d", i), 64'(bus.load_ready), (i < DEPTH - 1) ? 64'd1 : 64'd0);
    end
    load_word(32'hDEAD);
    check("over_ready", 64'(bus.load_ready), 64'd0);

    // Full FIFO in RUN: simultaneous load attempt and issue
    start_run(CNT_W'(DEPTH));
    check("full_valid", 64'(bus.addr_valid), 64'd1);
    check("full_addr",  64'(bus.address),    64'h100);
    check("full_ready", 64'(bus.load_ready), 64'd0);
    bus.load_valid = 1'b1;
    bus.load_addr  = 32'hBEEF;
    bus.addr_ready = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    check("pop_ready", 64'(bus.load_ready), 64'd1);
    check("pop_count", 64'(count),          64'd1);
    // Remaining DEPTH-1 words must be exactly the original ones, in order
    for (int i = 1; i < DEPTH; i++) begin
      check($sformatf("drain_addr_%0d", i), 64'(bus.address), 64'(32'h100 + i));
      tick();
    end
    check("drain_done",  64'(done),           64'd1);
    check("drain_count", 64'(count),          64'(DEPTH));
    check("drain_valid", 64'(bus.addr_valid), 64'd0);

    // Back-pressure holds the head, then reset mid-run
    bus.addr_ready = 1'b0;
    load_word(32'h55);
    load_word(32'h66);
    start_run(CNT_W'(2));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold_addr_%0d", i),  64'(bus.address),    64'h55);
      check($sformatf("hold_valid_%0d", i), 64'(bus.addr_valid), 64'd1);
      check($sformatf("hold_count_%0d", i), 64'(count),          64'd0);
      if (i < 3) tick();
    end
    reset          = 1'b1;
    bus.addr_ready = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_addr  = 32'h77;
    start          = 1'b1;
    trace_len      = CNT_W'(1);
    tick();
    reset          = 1'b0;
    bus.load_valid = 1'b0;
    start          = 1'b0;
    check("mrst_valid", 64'(bus.addr_valid), 64'd0);
    check("mrst_busy",  64'(busy),           64'd0);
    check("mrst_done",  64'(done),           64'd0);
    check("mrst_count", 64'(count),          64'd0);
    check("mrst_ready", 64'(bus.load_ready), 64'd1);
    // FIFO must be empty: a new run has nothing to issue
    start_run(CNT_W'(1));
    check("mrst_run_busy",  64'(busy),           64'd1);
    check("mrst_run_empty", 64'(bus.addr_valid), 64'd0);

`ifdef ADDR_TRACE_FEEDER_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("stall_rst", 64'(stall_cnt), 64'd0);
    start_run(CNT_W'(2));
    for (int i = 0; i < 4; i++) tick();
    load_word(32'h77);
    load_word(32'h88);
    tick();
    check("stall_done",  64'(done),      64'd1);
    check("stall_count", 64'(count),     64'd2);
    check("stall_cnt",   64'(stall_cnt), 64'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/addr_trace_feeder.md
ADDR_TRACE_FEEDER -- requirements
Module: addr_trace_feeder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter CNT_W, default 20, width of trace length and issue counters.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports load_valid  input  1, load_addr  input  ADDR_W, load_ready  output  1: trace-word write port.
REQ-007 SHALL have ports start  input  1 (begin run) and trace_len  input  CNT_W (addresses to issue), sampled when start is accepted.
REQ-008 SHALL have ports addr_valid  output  1, address  output  ADDR_W, addr_ready  input  1: issue port toward the cache.
REQ-009 SHALL have ports count  output  CNT_W (addresses issued this run), busy  output  1, done  output  1.

Function
REQ-010 SHALL hold a DEPTH-entry FIFO; load handshake when load_valid and load_ready; load_ready = not full.
REQ-011 SHALL give a loaded word a latency of 1 cycle: it can appear on address no earlier than the cycle after its load handshake, with no bypass.
REQ-012 SHALL, on simultaneous load and issue handshakes, update occupancy by net zero; a full FIFO keeps load_ready low even while an issue pops that cycle.
REQ-013 SHALL drive address from the FIFO head; address is don't-care while addr_valid is low.
REQ-014 SHALL use states IDLE, RUN, DONE; busy = (state==RUN); done = (state==DONE).
REQ-015 SHALL, in IDLE or DONE with start high: latch trace_len, clear count, go to RUN; if trace_len==0, go to DONE instead.
REQ-016 SHALL ignore start while in RUN.
REQ-017 SHALL, in RUN, drive addr_valid = FIFO not empty; addr_valid is 0 in IDLE and DONE.
REQ-018 SHALL, once addr_valid is asserted, hold address stable until the issue handshake (addr_valid and addr_ready).
REQ-019 SHALL increment count on each issue handshake; the handshake that makes count equal the latched length moves state to DONE on the same edge.
REQ-020 SHALL hold count in DONE until the next accepted start.
REQ-021 SHALL accept loads in every state; FIFO contents persist across DONE to the next run.
REQ-022 SHALL wrap FIFO pointers modulo DEPTH, with a separate full/empty distinction (extra pointer bit or occupancy counter).

Reset
REQ-023 SHALL, on reset, force state IDLE, empty FIFO, count=0, addr_valid=0, busy=0, done=0, load_ready=1, with stall counter (if built) =0.
REQ-024 SHALL, on reset asserted mid-RUN, abort the run and discard buffered words; reset overrides start and load on the same edge.

Configuration
REQ-025 SHALL, with macro ADDR_TRACE_FEEDER_STATS_EN defined, add output stall_cnt (CNT_W), counting RUN cycles with the FIFO empty, saturating at all-ones, cleared on accepted start.
REQ-026 SHALL, without ADDR_TRACE_FEEDER_STATS_EN, omit stall_cnt and its logic; all other behaviour is identical.

Verification
REQ-027 SHALL check: load 3 words 0x10,0x20,0x30; start with trace_len=3; addr_ready=1 -> address 0x10,0x20,0x30 on consecutive cycles, count 1,2,3, done=1 the cycle after the third.
REQ-028 SHALL check: load DEPTH words with no issue -> load_ready=0 after the DEPTH-th; a further load is not accepted and FIFO contents are unchanged.
REQ-029 SHALL check: in RUN with FIFO full, load_valid=1 and issue handshake in the same cycle -> load refused, occupancy drops to DEPTH-1, load_ready=1 next cycle.
REQ-030 SHALL check: start with trace_len=0 -> done=1 next cycle, addr_valid never asserted, count=0.
REQ-031 SHALL check: addr_ready=0 for 4 cycles with addr_valid=1 -> address held constant, count unchanged; reset in the 5th cycle -> IDLE, addr_valid=0, FIFO empty.
REQ-032 SHALL check, with STATS_EN: start trace_len=2 with empty FIFO, first load 5 cycles later -> stall_cnt=5 at done.
